// File: rtl/axi2apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// axi2apb_req_arbiter
//   Round-robin arbiter that shares one AXI-to-APB bridge REQ/ACK port among
//   NUM_REQ requesters. Only one transfer is in flight at a time. Read data and
//   error from the bridge are broadcast back and qualified by a per-requester
//   one-cycle S_ACK pulse.
//
// Ports
//   PRESETn, PCLK        async active-low reset, single clock
//   S_REQ / S_ACK        per-requester request level / done pulse
//   S_ADDR, S_WR, S_DATAW, S_BE, S_PROT
//                        packed per-requester transfer fields (slice i = req i)
//   S_DATAR, S_ERROR     broadcast response, valid while S_ACK is high
//   M_REQ / M_ACK        request to / done pulse from the bridge
//   M_ADDR, M_WR, M_DATAW, M_BE, M_PROT
//                        granted requester's fields (requester 0 when idle)
//   M_DATAR, M_ERROR     bridge response, valid with M_ACK
//   GNT                  one-hot current grant, 0 when idle
//   S_LOCK               (ARB_LOCK_EN only) per-requester grant lock request
//
// Configuration
//   ARB_LOCK_EN  when defined, adds S_LOCK: a requester holding S_LOCK in the
//                retire cycle is granted again at the next arbitration if it
//                still requests, bypassing rotation.
// ---------------------------------------------------------------------------
module axi2apb_req_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned WIDTH_PAD = 32,
    parameter int unsigned WIDTH_PDA = 32,
    parameter int unsigned WIDTH_PDS = WIDTH_PDA / 8
) (
    input  logic                           PRESETn,
    input  logic                           PCLK,
    // requester side
    input  logic [NUM_REQ-1:0]             S_REQ,
    output logic [NUM_REQ-1:0]             S_ACK,
    input  logic [NUM_REQ*WIDTH_PAD-1:0]   S_ADDR,
    input  logic [NUM_REQ-1:0]             S_WR,
    input  logic [NUM_REQ*WIDTH_PDA-1:0]   S_DATAW,
    input  logic [NUM_REQ*WIDTH_PDS-1:0]   S_BE,
    input  logic [NUM_REQ*3-1:0]           S_PROT,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             S_LOCK,
`endif
    output logic [WIDTH_PDA-1:0]           S_DATAR,
    output logic                           S_ERROR,
    // bridge side
    output logic                           M_REQ,
    input  logic                           M_ACK,
    output logic [WIDTH_PAD-1:0]           M_ADDR,
    output logic                           M_WR,
    output logic [WIDTH_PDA-1:0]           M_DATAW,
    output logic [WIDTH_PDS-1:0]           M_BE,
    output logic [2:0]                     M_PROT,
    input  logic [WIDTH_PDA-1:0]           M_DATAR,
    input  logic                           M_ERROR,
    output logic [NUM_REQ-1:0]             GNT
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RETIRE = 2'd2
    } state_t;

    // Registered state
    state_t                 state_q,  state_d;
    logic [IDX_W-1:0]       cur_q,    cur_d;     // granted index, 0 when idle
    logic [IDX_W-1:0]       last_q,   last_d;    // round-robin pointer
    logic [NUM_REQ-1:0]     gnt_q,    gnt_d;
    logic                   m_req_q,  m_req_d;
    logic [NUM_REQ-1:0]     s_ack_q,  s_ack_d;
    logic [WIDTH_PDA-1:0]   s_datar_q, s_datar_d;
    logic                   s_error_q, s_error_d;
`ifdef ARB_LOCK_EN
    logic                   lock_q,   lock_d;    // valid only for the first IDLE cycle
`endif

    // Round-robin search result
    logic                   arb_found;
    logic [IDX_W-1:0]       arb_idx;

    // First requesting index after last_q, wrapping modulo NUM_REQ
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(last_q) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!arb_found && S_REQ[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        logic             grant_vld;
        logic [IDX_W-1:0] grant_idx;

        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        m_req_d   = m_req_q;
        s_ack_d   = '0;
        s_datar_d = s_datar_q;
        s_error_d = s_error_q;
`ifdef ARB_LOCK_EN
        lock_d    = lock_q;
`endif
        grant_vld = 1'b0;
        grant_idx = '0;

        unique case (state_q)
            ST_IDLE: begin
`ifdef ARB_LOCK_EN
                // A locked requester re-wins without moving the pointer
                lock_d = 1'b0;
                if (lock_q && S_REQ[last_q]) begin
                    grant_vld = 1'b1;
                    grant_idx = last_q;
                end else if (arb_found) begin
                    grant_vld = 1'b1;
                    grant_idx = arb_idx;
                    last_d    = arb_idx;
                end
`else
                if (arb_found) begin
                    grant_vld = 1'b1;
                    grant_idx = arb_idx;
                    last_d    = arb_idx;
                end
`endif
                if (grant_vld) begin
                    cur_d   = grant_idx;
                    gnt_d   = NUM_REQ'(1) << grant_idx;
                    m_req_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // Completes even if the requester illegally drops S_REQ
                if (M_ACK) begin
                    m_req_d   = 1'b0;
                    s_datar_d = M_DATAR;
                    s_error_d = M_ERROR;
                    s_ack_d   = gnt_q;
                    state_d   = ST_RETIRE;
                end
            end

            ST_RETIRE: begin
`ifdef ARB_LOCK_EN
                lock_d  = S_LOCK[cur_q];
`endif
                gnt_d   = '0;
                cur_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                gnt_d   = '0;
                cur_d   = '0;
                m_req_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            gnt_q     <= '0;
            m_req_q   <= 1'b0;
            s_ack_q   <= '0;
            s_datar_q <= '0;
            s_error_q <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            m_req_q   <= m_req_d;
            s_ack_q   <= s_ack_d;
            s_datar_q <= s_datar_d;
            s_error_q <= s_error_d;
`ifdef ARB_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    assign S_ACK   = s_ack_q;
    assign S_DATAR = s_datar_q;
    assign S_ERROR = s_error_q;
    assign M_REQ   = m_req_q;
    assign GNT     = gnt_q;

    // Field mux from the registered grant index (requester 0 when idle)
    assign M_ADDR  = S_ADDR [int'(cur_q)*WIDTH_PAD +: WIDTH_PAD];
    assign M_WR    = S_WR   [cur_q];
    assign M_DATAW = S_DATAW[int'(cur_q)*WIDTH_PDA +: WIDTH_PDA];
    assign M_BE    = S_BE   [int'(cur_q)*WIDTH_PDS +: WIDTH_PDS];
    assign M_PROT  = S_PROT [int'(cur_q)*3 +: 3];

endmodule

// File: tb/tb_axi2apb_req_arbiter.sv
// Directed bench for axi2apb_req_arbiter with three requesters.
module tb_axi2apb_req_arbiter;

    localparam int unsigned N = 3;

    logic           PRESETn;
    logic           PCLK;
    logic [N-1:0]   S_REQ;
    logic [N-1:0]   S_ACK;
    logic [N*32-1:0] S_ADDR;
    logic [N-1:0]   S_WR;
    logic [N*32-1:0] S_DATAW;
    logic [N*4-1:0] S_BE;
    logic [N*3-1:0] S_PROT;
`ifdef ARB_LOCK_EN
    logic [N-1:0]   S_LOCK;
`endif
    logic [31:0]    S_DATAR;
    logic           S_ERROR;
    logic           M_REQ;
    logic           M_ACK;
    logic [31:0]    M_ADDR;
    logic           M_WR;
    logic [31:0]    M_DATAW;
    logic [3:0]     M_BE;
    logic [2:0]     M_PROT;
    logic [31:0]    M_DATAR;
    logic           M_ERROR;
    logic [N-1:0]   GNT;

    int tests = 0;
    int fails = 0;

    axi2apb_req_arbiter #(
        .NUM_REQ   (N),
        .WIDTH_PAD (32),
        .WIDTH_PDA (32),
        .WIDTH_PDS (4)
    ) dut (
        .PRESETn (PRESETn),
        .PCLK    (PCLK),
        .S_REQ   (S_REQ),
        .S_ACK   (S_ACK),
        .S_ADDR  (S_ADDR),
        .S_WR    (S_WR),
        .S_DATAW (S_DATAW),
        .S_BE    (S_BE),
        .S_PROT  (S_PROT),
`ifdef ARB_LOCK_EN
        .S_LOCK  (S_LOCK),
`endif
        .S_DATAR (S_DATAR),
        .S_ERROR (S_ERROR),
        .M_REQ   (M_REQ),
        .M_ACK   (M_ACK),
        .M_ADDR  (M_ADDR),
        .M_WR    (M_WR),
        .M_DATAW (M_DATAW),
        .M_BE    (M_BE),
        .M_PROT  (M_PROT),
        .M_DATAR (M_DATAR),
        .M_ERROR (M_ERROR),
        .GNT     (GNT)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic apply_reset();
        PRESETn = 1'b0;
        S_REQ   = '0;
        M_ACK   = 1'b0;
        M_ERROR = 1'b0;
        M_DATAR = '0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    // Waits (bounded) for M_REQ at a falling edge; n = falling edges waited minus one
    task automatic wait_mreq(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (M_REQ === 1'b1) begin
                ok = 1'b1;
                n  = k;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_mreq: M_REQ not seen within 20 cycles");
        end
    endtask

    // Bridge: pulse M_ACK after lat cycles, return at the RETIRE falling edge
    task automatic bridge_ack(input int lat, input logic [31:0] rdata, input logic err);
        repeat (lat) @(negedge PCLK);
        M_ACK   = 1'b1;
        M_DATAR = rdata;
        M_ERROR = err;
        @(negedge PCLK);
        M_ACK   = 1'b0;
        M_ERROR = 1'b0;
        M_DATAR = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (S_ACK !== 3'b000) begin fails++; $display("FAIL rst_s_ack: got %b exp 000", S_ACK); end
        tests++; if (S_DATAR !== 32'h0) begin fails++; $display("FAIL rst_s_datar: got %h exp 0", S_DATAR); end
        tests++; if (S_ERROR !== 1'b0) begin fails++; $display("FAIL rst_s_error: got %b exp 0", S_ERROR); end
        tests++; if (M_REQ !== 1'b0) begin fails++; $display("FAIL rst_m_req: got %b exp 0", M_REQ); end
        tests++; if (GNT !== 3'b000) begin fails++; $display("FAIL rst_gnt: got %b exp 000", GNT); end
        tests++; if (M_ADDR !== 32'h0000_0100) begin fails++; $display("FAIL rst_m_addr_idle: got %h exp 00000100", M_ADDR); end
    endtask

    task automatic test_single();
        bit ok; int n;
        S_WR  = 3'b000;
        S_REQ = 3'b001;
        wait_mreq(ok, n);
        tests++; if (n != 0) begin fails++; $display("FAIL single_latency: M_REQ after %0d extra cycles exp 0", n); end
        tests++; if (GNT !== 3'b001) begin fails++; $display("FAIL single_gnt: got %b exp 001", GNT); end
        tests++; if (M_ADDR !== 32'h0000_0100) begin fails++; $display("FAIL single_m_addr: got %h exp 00000100", M_ADDR); end
        tests++; if (M_WR !== 1'b0) begin fails++; $display("FAIL single_m_wr: got %b exp 0", M_WR); end
        tests++; if (M_BE !== 4'hF) begin fails++; $display("FAIL single_m_be: got %h exp f", M_BE); end
        bridge_ack(3, 32'hCAFE_F00D, 1'b0);
        tests++; if (S_ACK !== 3'b001) begin fails++; $display("FAIL single_s_ack: got %b exp 001", S_ACK); end
        tests++; if (S_DATAR !== 32'hCAFE_F00D) begin fails++; $display("FAIL single_s_datar: got %h exp cafef00d", S_DATAR); end
        tests++; if (S_ERROR !== 1'b0) begin fails++; $display("FAIL single_s_error: got %b exp 0", S_ERROR); end
        tests++; if (M_REQ !== 1'b0) begin fails++; $display("FAIL single_m_req_retire: got %b exp 0", M_REQ); end
        tests++; if (GNT !== 3'b001) begin fails++; $display("FAIL single_gnt_retire: got %b exp 001", GNT); end
        S_REQ = 3'b000;
        @(negedge PCLK);
        tests++; if (S_ACK !== 3'b000) begin fails++; $display("FAIL single_s_ack_pulse: got %b exp 000", S_ACK); end
        tests++; if (GNT !== 3'b000) begin fails++; $display("FAIL single_gnt_idle: got %b exp 000", GNT); end
    endtask

    task automatic test_contention();
        bit ok; int n;
        logic [N-1:0] exp_g;
        apply_reset();
        S_REQ = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            wait_mreq(ok, n);
            tests++; if (GNT !== exp_g) begin fails++; $display("FAIL cont_gnt[%0d]: got %b exp %b", k, GNT, exp_g); end
            tests++; if (M_ADDR !== 32'(((k % 3) + 1) * 256)) begin fails++; $display("FAIL cont_m_addr[%0d]: got %h", k, M_ADDR); end
            bridge_ack(1, 32'h1000 + 32'(k), 1'b0);
            tests++; if (S_ACK !== exp_g) begin fails++; $display("FAIL cont_s_ack[%0d]: got %b exp %b", k, S_ACK, exp_g); end
            tests++; if (S_DATAR !== 32'h1000 + 32'(k)) begin fails++; $display("FAIL cont_s_datar[%0d]: got %h", k, S_DATAR); end
        end
        S_REQ = 3'b000;
        @(negedge PCLK);
    endtask

    task automatic test_error();
        bit ok; int n;
        S_ADDR[32 +: 32]  = 32'h0000_FFFC;
        S_DATAW[32 +: 32] = 32'h1234_5678;
        S_WR              = 3'b010;
        S_REQ             = 3'b010;
        wait_mreq(ok, n);
        tests++; if (GNT !== 3'b010) begin fails++; $display("FAIL err_gnt: got %b exp 010", GNT); end
        tests++; if (M_ADDR !== 32'h0000_FFFC) begin fails++; $display("FAIL err_m_addr: got %h exp 0000fffc", M_ADDR); end
        tests++; if (M_WR !== 1'b1) begin fails++; $display("FAIL err_m_wr: got %b exp 1", M_WR); end
        tests++; if (M_DATAW !== 32'h1234_5678) begin fails++; $display("FAIL err_m_dataw: got %h exp 12345678", M_DATAW); end
        tests++; if (M_PROT !== 3'b010) begin fails++; $display("FAIL err_m_prot: got %b exp 010", M_PROT); end
        bridge_ack(2, 32'hDEAD_0000, 1'b1);
        tests++; if (S_ACK !== 3'b010) begin fails++; $display("FAIL err_s_ack: got %b exp 010", S_ACK); end
        tests++; if (S_ERROR !== 1'b1) begin fails++; $display("FAIL err_s_error: got %b exp 1", S_ERROR); end
        tests++; if (S_DATAR !== 32'hDEAD_0000) begin fails++; $display("FAIL err_s_datar_write: got %h exp dead0000", S_DATAR); end
        S_REQ = 3'b000;
        S_WR  = 3'b000;
        @(negedge PCLK);
        S_REQ = 3'b001;
        wait_mreq(ok, n);
        bridge_ack(0, 32'h5A5A_5A5A, 1'b0);
        tests++; if (S_ACK !== 3'b001) begin fails++; $display("FAIL err_next_s_ack: got %b exp 001", S_ACK); end
        tests++; if (S_ERROR !== 1'b0) begin fails++; $display("FAIL err_next_s_error: got %b exp 0", S_ERROR); end
        S_REQ = 3'b000;
        @(negedge PCLK);
    endtask

    task automatic test_spurious_ack();
        M_ACK   = 1'b1;
        M_ERROR = 1'b1;
        M_DATAR = 32'hFFFF_FFFF;
        @(negedge PCLK);
        M_ACK   = 1'b0;
        M_ERROR = 1'b0;
        M_DATAR = '0;
        tests++; if (S_ACK !== 3'b000) begin fails++; $display("FAIL spur_s_ack: got %b exp 000", S_ACK); end
        tests++; if (M_REQ !== 1'b0) begin fails++; $display("FAIL spur_m_req: got %b exp 0", M_REQ); end
        tests++; if (GNT !== 3'b000) begin fails++; $display("FAIL spur_gnt: got %b exp 000", GNT); end
        tests++; if (S_ERROR !== 1'b0) begin fails++; $display("FAIL spur_s_error: got %b exp 0", S_ERROR); end
        tests++; if (S_DATAR !== 32'h5A5A_5A5A) begin fails++; $display("FAIL spur_s_datar: got %h exp 5a5a5a5a", S_DATAR); end
        @(negedge PCLK);
        tests++; if (S_ACK !== 3'b000) begin fails++; $display("FAIL spur_s_ack_late: got %b exp 000", S_ACK); end
        tests++; if (M_ADDR !== 32'h0000_0100) begin fails++; $display("FAIL spur_m_addr_idle: got %h exp 00000100", M_ADDR); end
    endtask

    task automatic test_reset_mid_busy();
        bit ok; int n;
        S_REQ = 3'b001;
        wait_mreq(ok, n);
        PRESETn = 1'b0;
        S_REQ   = 3'b000;
        #1;
        tests++; if (M_REQ !== 1'b0) begin fails++; $display("FAIL rmid_m_req: got %b exp 0", M_REQ); end
        tests++; if (GNT !== 3'b000) begin fails++; $display("FAIL rmid_gnt: got %b exp 000", GNT); end
        tests++; if (S_ACK !== 3'b000) begin fails++; $display("FAIL rmid_s_ack: got %b exp 000", S_ACK); end
        @(negedge PCLK);
        PRESETn = 1'b1;
        S_REQ   = 3'b011;
        wait_mreq(ok, n);
        tests++; if (GNT !== 3'b001) begin fails++; $display("FAIL rmid_first_gnt: got %b exp 001", GNT); end
        bridge_ack(1, 32'h0, 1'b0);
        tests++; if (S_ACK !== 3'b001) begin fails++; $display("FAIL rmid_s_ack_after: got %b exp 001", S_ACK); end
        S_REQ = 3'b000;
        @(negedge PCLK);
    endtask

    // Requesters 0 and 1 request back to back; order depends on the lock feature
    task automatic test_back_to_back();
        bit ok; int n;
        logic [N-1:0] exp_g [3];
`ifdef ARB_LOCK_EN
        exp_g = '{3'b001, 3'b001, 3'b010};
        S_LOCK = 3'b001;
`else
        exp_g = '{3'b001, 3'b010, 3'b001};
`endif
        apply_reset();
        S_REQ = 3'b011;
        for (int k = 0; k < 3; k++) begin
            wait_mreq(ok, n);
`ifdef ARB_LOCK_EN
            if (k == 1) S_LOCK = 3'b000;
`endif
            tests++; if (GNT !== exp_g[k]) begin fails++; $display("FAIL b2b_gnt[%0d]: got %b exp %b", k, GNT, exp_g[k]); end
            bridge_ack(1, 32'h0, 1'b0);
            tests++; if (S_ACK !== exp_g[k]) begin fails++; $display("FAIL b2b_s_ack[%0d]: got %b exp %b", k, S_ACK, exp_g[k]); end
        end
        S_REQ = 3'b000;
        @(negedge PCLK);
    endtask

    initial begin
        PRESETn = 1'b0;
        S_REQ   = '0;
        S_WR    = '0;
        S_ADDR  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        S_DATAW = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        S_BE    = {4'h3, 4'hC, 4'hF};
        S_PROT  = {3'b100, 3'b010, 3'b001};
`ifdef ARB_LOCK_EN
        S_LOCK  = '0;
`endif
        M_ACK   = 1'b0;
        M_DATAR = '0;
        M_ERROR = 1'b0;

        test_reset();
        test_single();
        test_contention();
        S_ADDR[32 +: 32] = 32'h0000_0200;
        test_error();
        test_spurious_ack();
        S_ADDR[32 +: 32] = 32'h0000_0200;
        test_reset_mid_busy();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
